// File: rtl/instr_fetch.sv
// Instruction fetch FSM: requests words from instruction memory, presents them to the decoder, and
// handles stall, taken branches and HALT. Define ROE_FETCH_PERF_EN to add the o_fetch_count output.
module instr_fetch (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_imem_req,
  output logic [9:0]  o_imem_addr,
  input  logic [8:0]  i_imem_rdata,
  input  logic        i_imem_valid,
  output logic [8:0]  o_instr,
  output logic        o_instr_valid,
  output logic [9:0]  o_pc_out,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [9:0]  i_branch_target,
`ifdef ROE_FETCH_PERF_EN
  output logic [15:0] o_fetch_count,
`endif
  output logic        o_halted
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StIssue = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  localparam logic [8:0] HaltWord = 9'h1FF;

  logic [1:0] r_state;
  logic [9:0] r_pc;
  logic [8:0] r_instr;
  logic [9:0] r_pc_out;

  logic [1:0] w_state_d;
  logic [9:0] w_pc_d;
  logic       w_latch;

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_latch   = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) w_state_d = StFetch;
      end
      StFetch: begin
        if (i_imem_valid) begin
          // The HALT word is never issued and leaves the PC pointing at itself.
          if (i_imem_rdata == HaltWord) begin
            w_state_d = StHalt;
          end else begin
            w_state_d = StIssue;
            w_pc_d    = r_pc + 10'd1;
            w_latch   = 1'b1;
          end
        end
      end
      StIssue: begin
        if (!i_stall) begin
          w_state_d = StFetch;
          if (i_branch_taken) w_pc_d = i_branch_target;
        end
      end
      StHalt: begin
        if (i_start) begin
          w_state_d = StFetch;
          w_pc_d    = '0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_pc     <= '0;
      r_instr  <= '0;
      r_pc_out <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      if (w_latch) begin
        r_instr  <= i_imem_rdata;
        r_pc_out <= r_pc;
      end
    end
  end

`ifdef ROE_FETCH_PERF_EN
  logic [15:0] r_fetch_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_count <= '0;
    end else if (w_latch && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`endif

  assign o_imem_req    = (r_state == StFetch);
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = (r_state == StIssue);
  assign o_pc_out      = r_pc_out;
  assign o_halted      = (r_state == StHalt);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; expected values are hand-computed constants.
module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       imem_req;
  logic [9:0] imem_addr;
  logic [8:0] imem_rdata;
  logic       imem_valid;
  logic [8:0] instr;
  logic       instr_valid;
  logic [9:0] pc_out;
  logic       stall;
  logic       branch_taken;
  logic [9:0] branch_target;
  logic       halted;
`ifdef ROE_FETCH_PERF_EN
  logic [15:0] fetch_count;
`endif

  int n_checks;
  int n_errors;
  int exp_count;

  instr_fetch u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_rdata   (imem_rdata),
    .i_imem_valid   (imem_valid),
    .o_instr        (instr),
    .o_instr_valid  (instr_valid),
    .o_pc_out       (pc_out),
    .i_stall        (stall),
    .i_branch_taken (branch_taken),
    .i_branch_target(branch_target),
`ifdef ROE_FETCH_PERF_EN
    .o_fetch_count  (fetch_count),
`endif
    .o_halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one word from memory in the current FETCH cycle; leaves the DUT in ISSUE.
  task automatic mem_return(input logic [8:0] d);
    imem_valid = 1'b1;
    imem_rdata = d;
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
    if (d != 9'h1FF) exp_count++;
  endtask

  task automatic check_count(input string tag);
`ifdef ROE_FETCH_PERF_EN
    check(tag, fetch_count, 16'(exp_count));
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    exp_count     = 0;
    rst_n         = 1'b0;
    start         = 1'b0;
    imem_rdata    = '0;
    imem_valid    = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;

    // Reset state
    tick();
    tick();
    check("rst_req", 16'(imem_req), 16'd0);
    check("rst_ivalid", 16'(instr_valid), 16'd0);
    check("rst_addr", 16'(imem_addr), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    rst_n = 1'b1;
    tick();
    check("idle_req", 16'(imem_req), 16'd0);

    // First fetch with three wait cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fetch_req", 16'(imem_req), 16'd1);
    check("fetch_addr0", 16'(imem_addr), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_req", 16'(imem_req), 16'd1);
      check("wait_ivalid", 16'(instr_valid), 16'd0);
    end
    mem_return(9'h045);
    check("issue_instr", 16'(instr), 16'h045);
    check("issue_pc", 16'(pc_out), 16'd0);
    check("issue_ivalid", 16'(instr_valid), 16'd1);
    check("issue_req", 16'(imem_req), 16'd0);
    tick();
    check("next_ivalid", 16'(instr_valid), 16'd0);
    check("next_addr", 16'(imem_addr), 16'd1);
    check_count("count_1");

    // Stall holds the instruction; stray valid/start/branch are ignored
    mem_return(9'h0AA);
    stall        = 1'b1;
    start        = 1'b1;
    branch_taken = 1'b1;
    branch_target = 10'h155;
    imem_valid   = 1'b1;
    imem_rdata   = 9'h033;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_instr", 16'(instr), 16'h0AA);
      check("stall_pc", 16'(pc_out), 16'd1);
      check("stall_req", 16'(imem_req), 16'd0);
      check("stall_ivalid", 16'(instr_valid), 16'd1);
    end
    start        = 1'b0;
    branch_taken = 1'b0;
    imem_valid   = 1'b0;
    stall        = 1'b0;
    tick();
    check("unstall_addr", 16'(imem_addr), 16'd2);
    check("unstall_req", 16'(imem_req), 16'd1);

    // Walk to PC 5, then a taken branch after one stalled cycle
    for (int a = 2; a < 5; a++) begin
      mem_return(9'h010);
      tick();
    end
    check("addr5", 16'(imem_addr), 16'd5);
    mem_return(9'h011);
    check("pc5", 16'(pc_out), 16'd5);
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 10'h3F0;
    tick();
    check("br_stall_ivalid", 16'(instr_valid), 16'd1);
    check("br_stall_pc", 16'(pc_out), 16'd5);
    stall = 1'b0;
    tick();
    branch_taken = 1'b0;
    check("br_addr", 16'(imem_addr), 16'h3F0);

    // Branch only during stall must not redirect
    mem_return(9'h012);
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 10'h3FF;
    tick();
    branch_taken = 1'b0;
    stall        = 1'b0;
    tick();
    check("nobr_addr", 16'(imem_addr), 16'h3F1);

    // Branch in FETCH is ignored
    branch_taken  = 1'b1;
    branch_target = 10'h000;
    tick();
    branch_taken = 1'b0;
    check("fetch_br_addr", 16'(imem_addr), 16'h3F1);

    // Redirect to 1023 and check the wrap
    mem_return(9'h013);
    branch_taken  = 1'b1;
    branch_target = 10'h3FF;
    tick();
    branch_taken = 1'b0;
    check("addr_3ff", 16'(imem_addr), 16'h3FF);
    mem_return(9'h123);
    check("pc_3ff", 16'(pc_out), 16'h3FF);
    check("instr_123", 16'(instr), 16'h123);
    tick();
    check("wrap_addr", 16'(imem_addr), 16'd0);
    check_count("count_mid");

    // HALT at address 1
    mem_return(9'h014);
    tick();
    check("pre_halt_addr", 16'(imem_addr), 16'd1);
    mem_return(9'h1FF);
    check("halted", 16'(halted), 16'd1);
    check("halt_ivalid", 16'(instr_valid), 16'd0);
    check("halt_req", 16'(imem_req), 16'd0);
    check("halt_pc_kept", 16'(imem_addr), 16'd1);
    check("halt_instr", 16'(instr), 16'h014);
    imem_valid = 1'b1;
    imem_rdata = 9'h077;
    tick();
    imem_valid = 1'b0;
    check("halt_stays", 16'(halted), 16'd1);
    check_count("count_halt");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_halted", 16'(halted), 16'd0);
    check("restart_addr", 16'(imem_addr), 16'd0);
    check("restart_req", 16'(imem_req), 16'd1);

    // Reset in the middle of a fetch wait
    mem_return(9'h015);
    tick();
    check("pre_rst_addr", 16'(imem_addr), 16'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", 16'(imem_req), 16'd0);
    check("async_addr", 16'(imem_addr), 16'd0);
    check("async_instr", 16'(instr), 16'd0);
    check("async_pc", 16'(pc_out), 16'd0);
    exp_count = 0;
    check_count("count_rst");
    tick();
    rst_n = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 9'h055;
    tick();
    tick();
    imem_valid = 1'b0;
    check("stale_ivalid", 16'(instr_valid), 16'd0);
    check("stale_instr", 16'(instr), 16'd0);
    check("stale_req", 16'(imem_req), 16'd0);
    check("stale_halted", 16'(halted), 16'd0);
    check_count("count_stale");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
